// File: rtl/mem_ctrl.sv
// mem_ctrl: write-side controller for a 2**m x 2**m register bank.
// Round-robin arbitration of two write requesters onto the single bank
// write port, plus a bank-clear sequence that zeroes one row per cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting writes; a clr request starts the clear sequence
// CLEAR | zeroing rows 0..2**m-1, one per cycle; requests and clr ignored
module mem_ctrl #(
    parameter int m = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [m-1:0]      addr0,
    input  logic [2**m-1:0]   wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic [m-1:0]      addr1,
    input  logic [2**m-1:0]   wdata1,
    output logic              ack1,
    input  logic              clr,
    output logic              busy,
    output logic [2**m-1:0]   en,
    output logic [2**m-1:0]   d
);

    localparam int n = 2**m;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [m-1:0]     cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [n-1:0]     en_d;
    logic [n-1:0]     d_d;
    logic             gnt0, gnt1;

    // last_q = 1 means requester 1 won most recently, so 0 wins a tie
    assign gnt0 = req0 & (~req1 | last_q);
    assign gnt1 = req1 & (~req0 | ~last_q);
    assign busy = (state_q == CLEAR);

    // Register all state and the bank-facing outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            en      <= '0;
            d       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            en      <= en_d;
            d       <= d_d;
        end
    end

    // Next-state, grant and next bank-port values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        en_d    = '0;
        d_d     = d;
        ack0    = 1'b0;
        ack1    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (gnt0) begin
                    ack0        = 1'b1;
                    en_d[addr0] = 1'b1;
                    d_d         = wdata0;
                    last_d      = 1'b0;
                end else if (gnt1) begin
                    ack1        = 1'b1;
                    en_d[addr1] = 1'b1;
                    d_d         = wdata1;
                    last_d      = 1'b1;
                end
            end
            CLEAR: begin
                en_d[cnt_q] = 1'b1;
                d_d         = '0;
                cnt_d       = cnt_q + m'(1);
                if (cnt_q == {m{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // acks must read 0 for the whole time reset is held
        if (rst) begin
            ack0 = 1'b0;
            ack1 = 1'b0;
        end
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Write-side controller for the 2**m-row × 2**m-bit register bank built from per-row `pipo` registers (shared `d`, one-hot row `en`). It arbitrates two independent write requesters round-robin onto the bank's single write port. It also runs a bank-clear sequence that zeroes every row, one row per cycle. Its `en` and `d` outputs connect directly to the bank's `en` and `d` inputs on the same `clk`.

## Interface
- `m`, 4, log2 of row count and of row width (rows = width = 2**m)
- `clk`  in  1  clock; bank shares it
- `rst`  in  1  asynchronous, active-high reset
- `req0`  in  1  requester 0 write request (valid)
- `addr0`  in  m  requester 0 row address
- `wdata0`  in  2**m  requester 0 write data
- `ack0`  out  1  requester 0 accept (ready); transfer when `req0 & ack0`
- `req1`, `addr1`, `wdata1`, `ack1`: same as above, for requester 1
- `clr`  in  1  bank-clear request, sampled each cycle
- `busy`  out  1  clear sequence in progress
- `en`  out  2**m  one-hot row write enable to bank (registered)
- `d`  out  2**m  write data to bank (registered)

## Operation
- States: IDLE, CLEAR. Internal state: row counter `cnt` (m bits) and round-robin pointer `last` (1 bit, the last granted requester).
- IDLE, `clr`=0:
  - Single requester: that requester is granted.
  - Both requesters: grant goes to the requester ≠ `last`.
  - Grant is combinational: `ackX`=1 in the same cycle.
  - On the edge: `en` ← onehot(addrX), `d` ← wdataX, `last` ← X.
  - No request: `en` ← 0, `d` holds its value, `last` holds.
- IDLE, `clr`=1:
  - `ack0`=`ack1`=0; `clr` takes precedence over any request.
  - On the edge: state ← CLEAR, `cnt` ← 0, `en` ← 0.
- CLEAR:
  - `ack0`=`ack1`=0, `busy`=1; `clr` is ignored (no restart, no queuing).
  - Each edge: `en` ← onehot(`cnt`), `d` ← 0, `cnt` ← `cnt`+1.
  - When `cnt`=2**m−1: state ← IDLE on that edge.
  - `last` is unchanged by a clear.
- At most one bit of `en` is ever set; at most one of `ack0`/`ack1` is ever 1.
- Addresses are full-range; there is no out-of-range case.

## Timing
- Reset (async, immediate): state IDLE, `cnt`=0, `last`=1 (requester 0 wins the first tie), `en`=0, `d`=0, `busy`=0, `ack0`=`ack1`=0 while `rst` is high.
- Write latency:
  - Transfer in cycle N → `en`/`d` valid in cycle N+1.
  - Bank row updates at the end of N+1 and is visible on bank `q` in N+2.
- Requester rule: `addrX`/`wdataX` stable while `reqX`=1 and `ackX`=0; after an accepted cycle, new data or `reqX`=0 is presented next cycle.
- Sustained dual requests give one write per cycle, alternating 0,1,0,1…
- Clear timing, with `clr` high in IDLE at cycle N:
  - `busy`=1 in cycles N+1..N+2**m.
  - Row k enabled in cycle N+2+k.
  - IDLE again (acks possible) in cycle N+2**m+1; that cycle also outputs the last row clear.
  - Writes accepted after the clear land after it.
- `rst` mid-clear: sequence aborts immediately, outputs take reset values, and rows not yet cleared keep their contents.

## Test plan
- Reset: assert `rst` with `req0`=1, `clr`=1 → `en`=0, `d`=0, `ack0`=0, `busy`=0; release → first cycle `req0`, `addr0`=5, `wdata0`=16'hA5A5 → `ack0`=1 that cycle, next cycle `en`=16'h0020, `d`=16'hA5A5, bank row 5 = A5A5.
- Round-robin: both requests held from reset (`addr0`=1/`wdata0`=16'h1111, `addr1`=2/`wdata1`=16'h2222) for 4 cycles → acks 0,1,0,1; `en` 0002,0004,0002,0004 one cycle later.
- Single requester repeatedly: `req1` only, addresses 15,0,7 → `ack1`=1 every cycle, `en` = 8000, 0001, 0080 back-to-back, `last`=1 so a following tie grants 0.
- Clear: fill all rows with 16'hFFFF, pulse `clr` at cycle N → `busy` N+1..N+16, `en`=onehot(k) with `d`=0 at N+2+k, all bank rows 0 at N+18; `req0` held throughout gets `ack0` first at N+17.
- `clr` with simultaneous `req0` in IDLE → `ack0`=0 that cycle, clear runs; second `clr` pulse mid-clear → no extension (`busy` still exactly 16 cycles).
- `rst` asserted at cycle N+6 of a clear → `en`=0, `busy`=0 immediately; rows 0–3 read 0, rows 4–15 retain 16'hFFFF.
